// File: rtl/hybrid_rr_arbiter_if.sv
// Requester-side bundle for the hybrid-row round-robin arbiter.
// master = requester front ends, slave = the arbiter itself.
interface hybrid_rr_arbiter_if #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 4
);
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // req is a level request; done is a single-cycle release pulse from the owner.
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  done;
  logic [N_REQ-1:0]  gnt;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout;

  modport master (
    output req, done,
    input  gnt, gnt_valid, gnt_id, hold_cnt, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, gnt_id, hold_cnt, timeout
  );
endinterface

// File: rtl/hybrid_rr_arbiter.sv
// Round-robin owner selection for the shared hybrid-row cell chain, with a
// hold counter that bounds each tenure and a dead cycle between grants.
module hybrid_rr_arbiter #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hybrid_rr_arbiter_if.slave  bus,
  output logic                o_dbg_state
);
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t            r_state,   w_state_nxt;
  logic [N_REQ-1:0]  r_gnt,     w_gnt_nxt;
  logic              r_gnt_valid;
  logic [ID_W-1:0]   r_gnt_id,  w_gnt_id_nxt;
  logic [ID_W-1:0]   r_last,    w_last_nxt;
  logic [HOLD_W-1:0] r_hold,    w_hold_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic              w_found_hi;
  logic [ID_W-1:0]   w_pick_hi, w_pick_lo, w_pick_id;
  logic              w_own_done, w_own_req;

  // Lowest set bit above r_last wins; otherwise wrap to lowest set bit overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_pick_lo = ID_W'(i);
        if (i > int'(r_last)) begin
          w_found_hi = 1'b1;
          w_pick_hi  = ID_W'(i);
        end
      end
    end
    w_pick_id = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  // r_gnt is one-hot in GRANT, so masking isolates the owner's bits.
  assign w_own_done = |(bus.done & r_gnt);
  assign w_own_req  = |(bus.req  & r_gnt);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_nxt    = r_last;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_id;
          w_gnt_id_nxt = w_pick_id;
          w_hold_nxt   = '0;
          w_state_nxt  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_own_done || !w_own_req || (r_hold == HOLD_LAST)) begin
          w_gnt_nxt     = '0;
          w_last_nxt    = r_gnt_id;
          w_state_nxt   = S_IDLE;
          // Voluntary release takes precedence over hitting the limit.
          w_timeout_nxt = !(w_own_done || !w_own_req);
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last      <= ID_W'(N_REQ - 1);
      r_hold      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_last      <= w_last_nxt;
      r_hold      <= w_hold_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.hold_cnt  = r_hold;
  assign bus.timeout   = r_timeout;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_hybrid_rr_arbiter.sv
// Directed bench for hybrid_rr_arbiter (N_REQ=3, MAX_HOLD=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hybrid_rr_arbiter;
  logic clk;
  logic rst_n;
  logic dbg_state;
  int   n_checks;
  int   n_errors;

  hybrid_rr_arbiter_if #(.N_REQ(3), .MAX_HOLD(4)) bus ();

  hybrid_rr_arbiter #(.N_REQ(3), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [31:0] gnt, input logic [31:0] id,
                             input logic [31:0] hold, input logic [31:0] tmo);
    check({tag, ".gnt"},       32'(bus.gnt),       gnt);
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), (gnt != 0) ? 32'd1 : 32'd0);
    check({tag, ".gnt_id"},    32'(bus.gnt_id),    id);
    check({tag, ".hold_cnt"},  32'(bus.hold_cnt),  hold);
    check({tag, ".timeout"},   32'(bus.timeout),   tmo);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.req  = 3'b111;
    bus.done = 3'b000;

    // 1. reset held with all requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("reset_hold", 0, 0, 0, 0);
      check("reset_state", 32'(dbg_state), 0);
    end
    rst_n = 1'b1;
    tick();
    check_grant("first_grant", 32'b001, 0, 0, 0);
    check("first_state", 32'(dbg_state), 1);

    // 2. round-robin order, owner pulses done in its 2nd grant cycle
    for (int o = 0; o < 3; o++) begin
      check_grant("rr_c0", 32'(1 << o), 32'(o), 0, 0);
      tick();
      check_grant("rr_c1", 32'(1 << o), 32'(o), 1, 0);
      bus.done = 3'(1 << o);
      tick();
      check_grant("rr_dead", 0, 32'(o), 1, 0);
      bus.done = 3'b000;
      tick();
    end
    check_grant("rr_wrap", 32'b001, 0, 0, 0);

    // 3. forced release after MAX_HOLD cycles
    bus.req = 3'b000;
    tick();
    check_grant("drop_all", 0, 0, 0, 0);
    bus.req = 3'b010;
    tick();
    check_grant("force_h0", 32'b010, 1, 0, 0);
    for (int h = 1; h < 4; h++) begin
      tick();
      check_grant("force_hn", 32'b010, 1, 32'(h), 0);
    end
    tick();
    check_grant("force_rel", 0, 1, 3, 1);
    tick();
    check_grant("force_regrant", 32'b010, 1, 0, 0);

    // 4. non-owner done ignored; done coincident with limit is voluntary
    tick();
    check_grant("coin_h1", 32'b010, 1, 1, 0);
    bus.done = 3'b100;
    tick();
    check_grant("nonowner_done", 32'b010, 1, 2, 0);
    bus.done = 3'b000;
    tick();
    check_grant("coin_h3", 32'b010, 1, 3, 0);
    bus.done = 3'b010;
    tick();
    check_grant("coin_rel", 0, 1, 3, 0);
    bus.done = 3'b111;
    tick();
    check_grant("idle_done", 32'b010, 1, 0, 0);
    bus.done = 3'b000;

    // 5. request drop; first move the pointer to requester 2
    bus.req = 3'b100;
    tick();
    check_grant("drop1_rel", 0, 1, 0, 0);
    tick();
    check_grant("grant2", 32'b100, 2, 0, 0);
    bus.req = 3'b000;
    tick();
    check_grant("grant2_rel", 0, 2, 0, 0);
    bus.req = 3'b101;
    tick();
    check_grant("drop_c0", 32'b001, 0, 0, 0);
    tick();
    check_grant("drop_c1", 32'b001, 0, 1, 0);
    bus.req = 3'b100;
    tick();
    check_grant("drop_rel", 0, 0, 1, 0);
    tick();
    check_grant("drop_next", 32'b100, 2, 0, 0);

    // 6. asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    check_grant("async_rst", 0, 0, 0, 0);
    check("async_state", 32'(dbg_state), 0);
    bus.req = 3'b101;
    tick();
    check_grant("async_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_grant("post_rst", 32'b001, 0, 0, 0);
    tick();
    check_grant("post_rst_c1", 32'b001, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hybrid_rr_arbiter.md
Name: hybrid_rr_arbiter

Overview:
Round-robin arbiter that shares one hybrid-row cell chain among N_REQ requesters. Each requester stands for one of the independently clocked input paths of the hybrid-row test design. The block grants at most one owner at a time and bounds each tenure with a hold counter that forces release. It sits between the requester front ends and the shared datapath enable, and all state is in a single clock domain.

Parameters:
- N_REQ, 3, number of requesters (legal range 2..8).
- MAX_HOLD, 4, maximum cycles one grant may last before forced release (must be >= 1).
- ID_W, max(1,clog2(N_REQ)), width of gnt_id (derived; do not override).
- HOLD_W, clog2(MAX_HOLD+1), width of hold_cnt (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester level request.
- done  input  N_REQ  per-requester release pulse; only the current owner's bit is honoured.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  ID_W  index of the current owner; holds the last owner while idle.
- hold_cnt  output  HOLD_W  cycles elapsed in the current grant; 0 on the first grant cycle.
- timeout  output  1  one-cycle pulse flagging a forced release.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, timeout=0.
  - Round-robin pointer last=N_REQ-1, so req[0] has top priority after reset.
  - State goes to IDLE immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - When req!=0, pick the first set bit, searching from last+1 upward with wrap-around.
  - At that edge load gnt (one-hot), gnt_id and hold_cnt=0, and go to GRANT.
  - Latency: a request sampled at edge k produces a visible grant in cycle k+1.
  - When req==0, stay in IDLE with all outputs held except timeout=0.
- GRANT, owner o:
  - Release at the next edge if done[o]=1 or req[o]=0 (voluntary release).
  - Otherwise, if hold_cnt==MAX_HOLD-1, release at the next edge (forced release).
  - Otherwise hold_cnt increments by 1.
- On any release:
  - gnt=0, gnt_valid=0, last=o, state returns to IDLE.
  - gnt_id and hold_cnt keep their values until the next grant.
  - This guarantees at least one dead cycle between consecutive grants, including a re-grant to the same requester.
- timeout:
  - Registered; goes high for exactly one cycle (the first dead cycle) after a forced release only.
  - Stays 0 for voluntary releases and in every other case.
- Simultaneous events:
  - done[o] or a dropped req[o] in the same cycle as hold_cnt==MAX_HOLD-1 counts as a voluntary release; no timeout.
  - done bits of non-owners are ignored in every state.
  - done asserted in IDLE is ignored.
- MAX_HOLD=1: every grant lasts one cycle. timeout pulses unless done/drop coincides with that cycle.
- Fairness: with all requests held continuously, each requester receives a grant within N_REQ grant slots.
- Reset mid-grant: gnt clears asynchronously, the pointer resets to N_REQ-1, and there is no timeout pulse.
- No combinational path from any input to any output.

Test Plan:
1. Reset behaviour: hold rst_n=0 with req=3'b111 -> gnt=0, gnt_valid=0 and timeout=0 throughout. Deassert reset -> first grant is gnt=3'b001 one cycle after the first sampling edge.
2. Round-robin order: req=3'b111 held, owner pulses done in its 2nd grant cycle -> gnt sequence 001,001,000,010,010,000,100,100,000,001; timeout stays 0.
3. Forced release: MAX_HOLD=4, req=3'b010 held, no done -> gnt=010 with hold_cnt 0,1,2,3. Then gnt=000 and timeout=1 for one cycle, then gnt=010 again with hold_cnt=0.
4. Coincident done and limit: assert done[1] in the cycle where hold_cnt=3 -> release with timeout=0. A non-owner done[2] pulse mid-grant causes no change.
5. Request drop: owner req[0] falls in grant cycle 1 with req[2]=1 -> gnt 000 next cycle, then 100; no timeout.
6. Asynchronous reset mid-grant: pull rst_n low between edges while gnt=100 -> gnt=0 immediately. After release with req=3'b101 -> grant goes to 001 first.
